// File: rtl/dma_mch_rf.sv
// Multi-channel DMA register file: CPU register port, per-channel start/busy/done
// handshake and buffer-descriptor shadow registers. Optional IRQ via DMA_RF_IRQ_EN.
module dma_mch_rf #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int LEN_WD  = 12
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      core_req_i,
  output logic                      core_gnt_o,
  input  logic                      core_we_i,
  input  logic [ADDR_WD-1:0]        core_addr_i,
  input  logic [DATA_WD-1:0]        core_wdata_i,
  output logic [DATA_WD-1:0]        core_rdata_o,
  output logic                      core_rvalid_o,
  output logic [NUM_CH-1:0]         start_ch_req_o,
  input  logic [NUM_CH-1:0]         start_ch_ack_i,
  input  logic [NUM_CH-1:0]         ch_done_i,
  input  logic [2:0]                bd_ch_i,
  input  logic [2:0]                bd_cs_i,
  input  logic [DATA_WD-1:0]        bd_info_i,
  input  logic                      bd_update_i,
  output logic [NUM_CH*ADDR_WD-1:0] bd_addr_o,
  output logic [NUM_CH*ADDR_WD-1:0] src_addr_o,
  output logic [NUM_CH*ADDR_WD-1:0] dst_addr_o,
  output logic [NUM_CH*LEN_WD-1:0]  data_length_o,
  output logic [NUM_CH-1:0]         bd_last_o,
  output logic                      irq_o
);

  localparam logic [2:0] REG_CH_CTRL = 3'd0;
  localparam logic [2:0] REG_BD_ADDR = 3'd1;
  localparam logic [2:0] REG_BD_CTRL = 3'd2;
  localparam logic [2:0] REG_SRC     = 3'd3;
  localparam logic [2:0] REG_DST     = 3'd4;
  localparam logic [2:0] REG_STAT    = 3'd5;

  localparam logic [2:0] CS_CTRL = 3'd1;
  localparam logic [2:0] CS_SRC  = 3'd2;
  localparam logic [2:0] CS_DST  = 3'd3;
  localparam logic [2:0] CS_BD   = 3'd4;

  logic [2:0]         ch_s;
  logic [2:0]         reg_s;
  logic               rd_s;
  logic               wr_s;
  logic [NUM_CH-1:0]  ch_sel_s;
  logic               unused_addr_s;

  logic [NUM_CH-1:0]  start_q, start_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  ie_q, ie_d;
  logic [ADDR_WD-1:0] bd_addr_q [NUM_CH];
  logic [ADDR_WD-1:0] bd_addr_d [NUM_CH];
  logic [ADDR_WD-1:0] src_q [NUM_CH];
  logic [ADDR_WD-1:0] src_d [NUM_CH];
  logic [ADDR_WD-1:0] dst_q [NUM_CH];
  logic [ADDR_WD-1:0] dst_d [NUM_CH];
  logic [DATA_WD-1:0] bd_ctrl_q [NUM_CH];
  logic [DATA_WD-1:0] bd_ctrl_d [NUM_CH];
  logic [DATA_WD-1:0] rd_word_s [NUM_CH];
  logic [DATA_WD-1:0] rdata_q, rdata_d;
  logic               rvalid_q;
  logic               irq_q, irq_d;

  assign ch_s          = core_addr_i[7:5];
  assign reg_s         = core_addr_i[4:2];
  assign rd_s          = core_req_i & ~core_we_i;
  assign wr_s          = core_req_i & core_we_i;
  assign unused_addr_s = ^{core_addr_i[ADDR_WD-1:8], core_addr_i[1:0]};

  assign core_gnt_o     = 1'b1;
  assign core_rdata_o   = rdata_q;
  assign core_rvalid_o  = rvalid_q;
  assign start_ch_req_o = start_q;
  assign irq_o          = irq_q;

  // Out-of-range channel indices never match, so their reads return 0 and writes drop.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_sel_s[g]                         = (ch_s == 3'(g));
    assign bd_addr_o[g*ADDR_WD +: ADDR_WD]     = bd_addr_q[g];
    assign src_addr_o[g*ADDR_WD +: ADDR_WD]    = src_q[g];
    assign dst_addr_o[g*ADDR_WD +: ADDR_WD]    = dst_q[g];
    assign data_length_o[g*LEN_WD +: LEN_WD]   = bd_ctrl_q[g][LEN_WD-1:0];
    assign bd_last_o[g]                        = bd_ctrl_q[g][21];
  end

  // Per-channel read word selection
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      rd_word_s[n] = {DATA_WD{1'b0}};
      case (reg_s)
        REG_CH_CTRL: rd_word_s[n] = DATA_WD'({ie_q[n], start_q[n]});
        REG_BD_ADDR: rd_word_s[n] = DATA_WD'(bd_addr_q[n]);
        REG_BD_CTRL: rd_word_s[n] = bd_ctrl_q[n];
        REG_SRC:     rd_word_s[n] = DATA_WD'(src_q[n]);
        REG_DST:     rd_word_s[n] = DATA_WD'(dst_q[n]);
        REG_STAT:    rd_word_s[n] = DATA_WD'({done_q[n], busy_q[n]});
        default:     rd_word_s[n] = {DATA_WD{1'b0}};
      endcase
    end
  end

  // Read data capture: the response is updated only on a read request
  always_comb begin
    rdata_d = {DATA_WD{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      rdata_d = rdata_d | ({DATA_WD{ch_sel_s[n]}} & rd_word_s[n]);
    end
    if (!rd_s) begin
      rdata_d = rdata_q;
    end else begin
      rdata_d = rdata_d;
    end
  end

  // Channel state next-state: CPU effects first, internal events overwrite them
  always_comb begin
    start_d   = start_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ie_d      = ie_q;
    bd_addr_d = bd_addr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    bd_ctrl_d = bd_ctrl_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr_s && ch_sel_s[n] && (reg_s == REG_CH_CTRL)) begin
`ifdef DMA_RF_IRQ_EN
        ie_d[n] = core_wdata_i[1];
`else
        ie_d[n] = 1'b0;
`endif
        if (core_wdata_i[0] && !busy_q[n] && !start_q[n]) begin
          start_d[n] = 1'b1;
        end else begin
          start_d[n] = start_q[n];
        end
      end else begin
        ie_d[n] = ie_q[n];
      end

      if (start_ch_ack_i[n]) begin
        start_d[n] = 1'b0;
        busy_d[n]  = 1'b1;
      end else if (ch_done_i[n]) begin
        busy_d[n]  = 1'b0;
      end else begin
        busy_d[n]  = busy_q[n];
      end

      if (ch_done_i[n]) begin
        done_d[n] = 1'b1;
      end else if (wr_s && ch_sel_s[n] && (reg_s == REG_STAT) && core_wdata_i[1]) begin
        done_d[n] = 1'b0;
      end else begin
        done_d[n] = done_q[n];
      end

      if (wr_s && ch_sel_s[n] && (reg_s == REG_BD_ADDR)) begin
        bd_addr_d[n] = ADDR_WD'(core_wdata_i);
      end else begin
        bd_addr_d[n] = bd_addr_q[n];
      end

      if (bd_update_i && (bd_ch_i == 3'(n))) begin
        case (bd_cs_i)
          CS_CTRL: bd_ctrl_d[n] = bd_info_i;
          CS_SRC:  src_d[n]     = ADDR_WD'(bd_info_i);
          CS_DST:  dst_d[n]     = ADDR_WD'(bd_info_i);
          CS_BD:   bd_addr_d[n] = ADDR_WD'(bd_info_i);
          default: bd_ctrl_d[n] = bd_ctrl_q[n];
        endcase
      end else begin
        bd_ctrl_d[n] = bd_ctrl_q[n];
      end
    end

`ifdef DMA_RF_IRQ_EN
    irq_d = |(done_q & ie_q);
`else
    irq_d = 1'b0;
`endif
  end

  // State registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      start_q  <= {NUM_CH{1'b0}};
      busy_q   <= {NUM_CH{1'b0}};
      done_q   <= {NUM_CH{1'b0}};
      ie_q     <= {NUM_CH{1'b0}};
      rdata_q  <= {DATA_WD{1'b0}};
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        bd_addr_q[n] <= {ADDR_WD{1'b0}};
        src_q[n]     <= {ADDR_WD{1'b0}};
        dst_q[n]     <= {ADDR_WD{1'b0}};
        bd_ctrl_q[n] <= {DATA_WD{1'b0}};
      end
    end else begin
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ie_q      <= ie_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_s;
      irq_q     <= irq_d;
      bd_addr_q <= bd_addr_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      bd_ctrl_q <= bd_ctrl_d;
    end
  end

endmodule

// File: tb/tb_dma_mch_rf.sv
// Directed self-checking bench for dma_mch_rf; read responses are checked through
// an expected-value queue. IRQ/IE expectations follow DMA_RF_IRQ_EN.
module tb_dma_mch_rf;

  localparam int NUM_CH = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LW     = 12;

`ifdef DMA_RF_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 core_req;
  logic                 core_gnt;
  logic                 core_we;
  logic [AW-1:0]        core_addr;
  logic [DW-1:0]        core_wdata;
  logic [DW-1:0]        core_rdata;
  logic                 core_rvalid;
  logic [NUM_CH-1:0]    start_req;
  logic [NUM_CH-1:0]    start_ack;
  logic [NUM_CH-1:0]    ch_done;
  logic [2:0]           bd_ch;
  logic [2:0]           bd_cs;
  logic [DW-1:0]        bd_info;
  logic                 bd_update;
  logic [NUM_CH*AW-1:0] bd_addr;
  logic [NUM_CH*AW-1:0] src_addr;
  logic [NUM_CH*AW-1:0] dst_addr;
  logic [NUM_CH*LW-1:0] data_length;
  logic [NUM_CH-1:0]    bd_last;
  logic                 irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  dma_mch_rf #(.NUM_CH(NUM_CH), .ADDR_WD(AW), .DATA_WD(DW), .LEN_WD(LW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .core_req_i(core_req), .core_gnt_o(core_gnt), .core_we_i(core_we),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_rdata_o(core_rdata), .core_rvalid_o(core_rvalid),
    .start_ch_req_o(start_req), .start_ch_ack_i(start_ack), .ch_done_i(ch_done),
    .bd_ch_i(bd_ch), .bd_cs_i(bd_cs), .bd_info_i(bd_info), .bd_update_i(bd_update),
    .bd_addr_o(bd_addr), .src_addr_o(src_addr), .dst_addr_o(dst_addr),
    .data_length_o(data_length), .bd_last_o(bd_last), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
    @(negedge clk);
    core_req = 1'b0; core_we = 1'b0;
  endtask

  // Issue one read; the expected word is queued now and consumed when rvalid shows up.
  task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] e);
    sb.push_back(e);
    core_req = 1'b1; core_we = 1'b0; core_addr = a;
    @(negedge clk);
    core_req = 1'b0;
    check({tag, "_rvalid"}, 32'(core_rvalid), 32'd1);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      check(tag, core_rdata, sb.pop_front());
    end
  endtask

  task automatic bd_load(input logic [2:0] c, input logic [2:0] s, input logic [31:0] info);
    bd_update = 1'b1; bd_ch = c; bd_cs = s; bd_info = info;
    @(negedge clk);
    bd_update = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    start_ack = 4'b0; ch_done = 4'b0; bd_ch = 3'd0; bd_cs = 3'd0; bd_info = 32'h0;
    bd_update = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(start_req), 32'h0);
    check("rst_rvalid", 32'(core_rvalid), 32'h0);
    check("rst_rdata", core_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("gnt", 32'(core_gnt), 32'h1);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_rvalid", 32'(core_rvalid), 32'h0);
    rd_exp("rd_ctrl0_rst", 32'h00, 32'h0);

    // ch1 start handshake
    wr(32'h20, 32'h1);
    check("start_req_ch1", 32'(start_req), 32'h2);
    @(negedge clk);
    check("start_req_held", 32'(start_req), 32'h2);
    start_ack = 4'b0010;
    @(negedge clk);
    start_ack = 4'b0000;
    check("start_req_cleared", 32'(start_req), 32'h0);
    rd_exp("rd_stat1_busy", 32'h34, 32'h1);

    // BD_ADDR write/read, then back-to-back reads
    wr(32'h44, 32'h1000_0000);
    rd_exp("rd_bdaddr2", 32'h44, 32'h1000_0000);
    check("bd_addr_o2", bd_addr[2*AW +: AW], 32'h1000_0000);
    rd_exp("b2b_a", 32'h34, 32'h1);
    rd_exp("b2b_b", 32'h44, 32'h1000_0000);
    @(negedge clk);
    check("rvalid_drop", 32'(core_rvalid), 32'h0);

    // BD updates from the descriptor engine
    bd_load(3'd3, 3'd1, 32'h0020_0040);
    check("len3", 32'(data_length[3*LW +: LW]), 32'h040);
    check("last", 32'(bd_last), 32'h8);
    rd_exp("rd_bdctrl3", 32'h68, 32'h0020_0040);
    bd_load(3'd3, 3'd2, 32'hAAAA_5555);
    check("src3", src_addr[3*AW +: AW], 32'hAAAA_5555);
    bd_load(3'd3, 3'd3, 32'h5A5A_0F0F);
    check("dst3", dst_addr[3*AW +: AW], 32'h5A5A_0F0F);
    bd_load(3'd3, 3'd5, 32'hDEAD_BEEF);
    bd_load(3'd5, 3'd2, 32'hDEAD_BEEF);
    wr(32'h6C, 32'h1234_5678);
    rd_exp("src_ro", 32'h6C, 32'hAAAA_5555);

    // BD update beats CPU write to BD_ADDR
    bd_update = 1'b1; bd_ch = 3'd0; bd_cs = 3'd4; bd_info = 32'h2222_0000;
    wr(32'h04, 32'h1111_0000);
    bd_update = 1'b0;
    rd_exp("bd_prio", 32'h04, 32'h2222_0000);

    // Unmapped register / channel
    rd_exp("rd_reg6", 32'h18, 32'h0);
    wr(32'hA4, 32'hFFFF_FFFF);
    rd_exp("rd_ch5", 32'hA4, 32'h0);

    // ch0 start, then START while busy is ignored
    wr(32'h00, 32'h3);
    check("start_req_ch0", 32'(start_req), 32'h1);
    start_ack = 4'b0001;
    @(negedge clk);
    start_ack = 4'b0000;
    wr(32'h00, 32'h3);
    check("start_busy_ign", 32'(start_req), 32'h0);
    rd_exp("rd_ctrl0_ie", 32'h00, {30'd0, IRQ_ON, 1'b0});
    rd_exp("rd_stat0_busy", 32'h14, 32'h1);

    // ack beats a same-cycle CPU START on ch2
    start_ack = 4'b0100;
    wr(32'h40, 32'h1);
    start_ack = 4'b0000;
    check("ack_prio", 32'(start_req), 32'h0);
    rd_exp("rd_stat2", 32'h54, 32'h1);

    // done beats same-cycle W1C; IRQ follows DONE & IE
    ch_done = 4'b0001;
    wr(32'h14, 32'h2);
    ch_done = 4'b0000;
    rd_exp("done_prio", 32'h14, 32'h2);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(32'h14, 32'h0);
    rd_exp("w1c_zero", 32'h14, 32'h2);
    wr(32'h14, 32'h2);
    check("irq_hold", 32'(irq), 32'(IRQ_ON));
    rd_exp("w1c_clear", 32'h14, 32'h0);
    check("irq_clr", 32'(irq), 32'h0);

    // done on an idle channel
    ch_done = 4'b1000;
    @(negedge clk);
    ch_done = 4'b0000;
    rd_exp("done_idle", 32'h74, 32'h2);

    // reset in the middle of a read
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h44;
    #2 rstn = 1'b0;
    #1 core_req = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(core_rvalid), 32'h0);
    check("mid_rst_rdata", core_rdata, 32'h0);
    check("mid_rst_bdaddr", bd_addr[2*AW +: AW], 32'h0);
    check("mid_rst_src", src_addr[3*AW +: AW], 32'h0);
    check("mid_rst_len", 32'(data_length[3*LW +: LW]), 32'h0);
    check("mid_rst_last", 32'(bd_last), 32'h0);
    check("mid_rst_req", 32'(start_req), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_rvalid", 32'(core_rvalid), 32'h0);
    rd_exp("post_rst_stat", 32'h34, 32'h0);
    rd_exp("post_rst_bd", 32'h04, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
